// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one valid/ready memory slave between fetch (m0) and load/store (m1).
// Request latched into s_* on grant; master ready mirrors slave ready; a DONE gap follows every transaction.
module mem_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 64,
   parameter logic [31:0] ERR_RDATA      = 32'hDEAD_BEEF
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        m0_valid,
   output logic        m0_ready,
   input  logic [31:0] m0_addr,
   input  logic [31:0] m0_wdata,
   input  logic [3:0]  m0_wstrb,
   output logic [31:0] m0_rdata,
   output logic        m0_err,
   input  logic        m1_valid,
   output logic        m1_ready,
   input  logic [31:0] m1_addr,
   input  logic [31:0] m1_wdata,
   input  logic [3:0]  m1_wstrb,
   output logic [31:0] m1_rdata,
   output logic        m1_err,
   output logic        s_valid,
   input  logic        s_ready,
   output logic [31:0] s_addr,
   output logic [31:0] s_wdata,
   output logic [3:0]  s_wstrb,
   input  logic [31:0] s_rdata,
   output logic        busy,
   output logic        grant
);

   localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, GRANT0, GRANT1, DONE} state_t;

   state_t        state_q, state_d;
   logic          last_grant_q, last_grant_d;
   logic [31:0]   addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic [3:0]    wstrb_q, wstrb_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic granted, owner, timeout_hit, finish, abort;
   logic [31:0] resp_rdata;

   assign granted     = (state_q == GRANT0) || (state_q == GRANT1);
   assign owner       = (state_q == GRANT1);
   assign timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt_q == CW'(TIMEOUT_CYCLES - 1));
   // reset_n gates completion so a transaction cut by reset never reports back
   assign finish      = reset_n && granted && (s_ready || timeout_hit);
   assign abort       = finish && !s_ready;
   assign resp_rdata  = abort ? ERR_RDATA : s_rdata;

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      wstrb_d      = wstrb_q;
      cnt_d        = cnt_q;
      case (state_q)
         IDLE: begin
            if (m0_valid && (!m1_valid || last_grant_q)) begin
               state_d = GRANT0;
               addr_d  = m0_addr;
               wdata_d = m0_wdata;
               wstrb_d = m0_wstrb;
               cnt_d   = '0;
            end else if (m1_valid) begin
               state_d = GRANT1;
               addr_d  = m1_addr;
               wdata_d = m1_wdata;
               wstrb_d = m1_wstrb;
               cnt_d   = '0;
            end
         end
         GRANT0, GRANT1: begin
            if (finish) begin
               state_d      = DONE;
               last_grant_d = owner;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         last_grant_q <= 1'b1;
         addr_q       <= '0;
         wdata_q      <= '0;
         wstrb_q      <= '0;
         cnt_q        <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         wstrb_q      <= wstrb_d;
         cnt_q        <= cnt_d;
      end
   end

   assign s_valid = granted;
   assign busy    = granted;
   assign grant   = owner;
   assign s_addr  = addr_q;
   assign s_wdata = wdata_q;
   assign s_wstrb = wstrb_q;

   assign m0_ready = finish && !owner;
   assign m0_err   = m0_ready && abort;
   assign m0_rdata = m0_ready ? resp_rdata : '0;
   assign m1_ready = finish && owner;
   assign m1_err   = m1_ready && abort;
   assign m1_rdata = m1_ready ? resp_rdata : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a 3-wait-state BRAM slave model.
module tb_mem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        m0_valid, m0_ready, m0_err, m1_valid, m1_ready, m1_err;
   logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_wdata, m1_rdata;
   logic [3:0]  m0_wstrb, m1_wstrb, s_wstrb;
   logic        s_valid, s_ready, busy, grant;
   logic [31:0] s_addr, s_wdata, s_rdata;

   logic        slave_en, man_ready;
   logic [2:0]  wcnt_q = '0;
   logic [31:0] mem [64];
   bit          wr_q [64];
   logic        model_ready;
   logic [5:0]  idx;

   int vectors = 0;
   int fails   = 0;
   int n;
   bit exp_g [4];

   always #5 clk = ~clk;

   mem_arbiter #(.TIMEOUT_CYCLES(8), .ERR_RDATA(32'hDEAD_BEEF)) dut (
      .clk(clk), .reset_n(reset_n),
      .m0_valid(m0_valid), .m0_ready(m0_ready), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_wstrb(m0_wstrb), .m0_rdata(m0_rdata), .m0_err(m0_err),
      .m1_valid(m1_valid), .m1_ready(m1_ready), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_wstrb(m1_wstrb), .m1_rdata(m1_rdata), .m1_err(m1_err),
      .s_valid(s_valid), .s_ready(s_ready), .s_addr(s_addr), .s_wdata(s_wdata),
      .s_wstrb(s_wstrb), .s_rdata(s_rdata), .busy(busy), .grant(grant)
   );

   // Slave: ready in the 4th cycle of s_valid; unwritten words read as A500_00<addr>
   assign idx         = s_addr[7:2];
   assign model_ready = s_valid && (wcnt_q == 3'd3);
   assign s_ready     = slave_en ? model_ready : man_ready;
   assign s_rdata     = wr_q[idx] ? mem[idx] : {24'hA5_0000, s_addr[7:0]};

   always @(posedge clk) begin
      wcnt_q <= s_valid ? wcnt_q + 3'd1 : 3'd0;
      if (s_valid && s_ready && (s_wstrb != 4'b0000)) begin
         for (int b = 0; b < 4; b++)
            if (s_wstrb[b]) mem[idx][8*b +: 8] <= s_wdata[8*b +: 8];
         wr_q[idx] <= 1'b1;
      end
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic wait_rdy(input bit m, output int cycles);
      cycles = 0;
      do begin
         tick();
         cycles++;
      end while (!(m ? m1_ready : m0_ready) && cycles < 20);
   endtask

   initial begin
      reset_n = 1'b0; slave_en = 1'b1; man_ready = 1'b0;
      m0_valid = 0; m0_addr = 0; m0_wdata = 0; m0_wstrb = 0;
      m1_valid = 0; m1_addr = 0; m1_wdata = 0; m1_wstrb = 0;
      exp_g = '{1'b0, 1'b1, 1'b0, 1'b1};
      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_svalid", s_valid, 0);
      chk("rst_saddr", s_addr, 0);
      chk("rst_m0_ready", m0_ready, 0);
      chk("rst_m1_ready", m1_ready, 0);
      reset_n = 1'b1;

      // lone m0 read of 0x10
      m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'h0;
      tick();
      chk("t1_svalid", s_valid, 1);
      chk("t1_saddr", s_addr, 32'h10);
      chk("t1_swstrb", s_wstrb, 0);
      chk("t1_grant", grant, 0);
      chk("t1_early_ready", m0_ready, 0);
      tick(); tick();
      chk("t1_wait_ready", m0_ready, 0);
      tick();
      chk("t1_m0_ready", m0_ready, 1);
      chk("t1_m0_rdata", m0_rdata, 32'hA500_0010);
      chk("t1_m0_err", m0_err, 0);
      chk("t1_m1_ready", m1_ready, 0);
      tick();
      chk("t1_done_svalid", s_valid, 0);
      chk("t1_done_ready", m0_ready, 0);
      m0_valid = 0;
      tick();

      // m1 write; payload change after grant must not leak to the slave
      m1_valid = 1; m1_addr = 32'h20; m1_wdata = 32'hCAFE_BABE; m1_wstrb = 4'hF;
      tick();
      chk("t2_grant", grant, 1);
      chk("t2_saddr", s_addr, 32'h20);
      m1_addr = 32'h99;
      tick();
      chk("t2_saddr_held", s_addr, 32'h20);
      tick(); tick();
      chk("t2_m1_ready", m1_ready, 1);
      chk("t2_m0_ready", m0_ready, 0);
      chk("t2_saddr_end", s_addr, 32'h20);
      chk("t2_swdata_end", s_wdata, 32'hCAFE_BABE);
      tick();
      chk("t2_gap_svalid", s_valid, 0);
      chk("t2_mem", mem[8], 32'hCAFE_BABE);
      m1_valid = 0;
      tick();

      // tie after reset, both held: grants 0,1,0,1
      reset_n = 0;
      tick();
      reset_n = 1;
      m0_valid = 1; m0_addr = 32'h30; m1_valid = 1; m1_addr = 32'h34; m1_wstrb = 4'h0;
      tick();
      for (int k = 0; k < 4; k++) begin
         chk("t3_busy", busy, 1);
         chk("t3_grant", grant, exp_g[k]);
         tick(); tick(); tick();
         chk("t3_m0_ready", m0_ready, !exp_g[k]);
         chk("t3_m1_ready", m1_ready, exp_g[k]);
         tick();
         chk("t3_done_busy", busy, 0);
         if (k == 3) begin
            m0_valid = 0; m1_valid = 0;
         end
         tick(); tick();
      end
      chk("t3_end_idle", busy, 0);

      // silent slave: abort in the 8th grant cycle
      slave_en = 0;
      m0_valid = 1; m0_addr = 32'h50;
      tick();
      chk("t4_busy", busy, 1);
      repeat (6) tick();
      chk("t4_no_early_abort", m0_ready, 0);
      tick();
      chk("t4_m0_ready", m0_ready, 1);
      chk("t4_m0_err", m0_err, 1);
      chk("t4_m0_rdata", m0_rdata, 32'hDEAD_BEEF);
      chk("t4_m1_ready", m1_ready, 0);
      tick();
      m0_valid = 0; man_ready = 1;
      #1;
      chk("t4_late_svalid", s_valid, 0);
      chk("t4_late_ready", m0_ready, 0);
      chk("t4_late_err", m0_err, 0);
      tick();
      chk("t4_idle_busy", busy, 0);
      tick();
      chk("t4_no_retrigger", busy, 0);
      man_ready = 0; slave_en = 1;

      // reset during GRANT1 abandons the write; next tie goes to m0
      m1_valid = 1; m1_addr = 32'h60; m1_wdata = 32'h1111_2222; m1_wstrb = 4'hF;
      tick();
      chk("t5_grant", grant, 1);
      tick();
      reset_n = 0;
      tick();
      chk("t5_busy", busy, 0);
      chk("t5_svalid", s_valid, 0);
      chk("t5_m1_ready", m1_ready, 0);
      reset_n = 1;
      m0_valid = 1; m0_addr = 32'h10; m0_wstrb = 4'h0;
      tick();
      chk("t5_tie_grant", grant, 0);
      chk("t5_tie_busy", busy, 1);
      tick(); tick(); tick();
      chk("t5_m0_ready", m0_ready, 1);
      chk("t5_m1_quiet", m1_ready, 0);
      tick();
      m0_valid = 0; m1_valid = 0;
      tick();
      chk("t5_no_write", wr_q[24], 0);

      // write then read back 0x40, 4 cycles per request
      m1_valid = 1; m1_addr = 32'h40; m1_wdata = 32'h1234_5678; m1_wstrb = 4'hF;
      wait_rdy(1'b1, n);
      chk("t6_wr_latency", n, 4);
      chk("t6_wr_err", m1_err, 0);
      tick();
      m1_valid = 0;
      tick();
      m0_valid = 1; m0_addr = 32'h40; m0_wstrb = 4'h0;
      wait_rdy(1'b0, n);
      chk("t6_rd_latency", n, 4);
      chk("t6_rd_data", m0_rdata, 32'h1234_5678);
      tick();
      m0_valid = 0;
      tick();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
      $finish;
   end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Two-master, one-slave arbiter. It shares the single-port BRAM controller between instruction fetch (master 0) and the load/store unit (master 1).
- Every port on both sides uses the team's valid/ready memory protocol. The slave port connects directly to the BRAM controller's mem_* port.
- Adds request latching, round-robin fairness and a transaction timeout. A missing or hung slave therefore cannot stall the CPU forever.

Parameters:
- TIMEOUT_CYCLES, 64: cycles in a grant state without s_ready before the arbiter aborts the transaction. 0 disables the timeout.
- ERR_RDATA, 32'hDEAD_BEEF: read data returned to the master on an aborted transaction.

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- m0_valid  input  1  master 0 request
- m0_ready  output  1  master 0 completion pulse
- m0_addr  input  32  master 0 byte address
- m0_wdata  input  32  master 0 write data
- m0_wstrb  input  4  master 0 write strobe; 4'b0000 = read
- m0_rdata  output  32  master 0 read data, valid while m0_ready=1
- m0_err  output  1  master 0 timeout flag, valid while m0_ready=1
- m1_valid, m1_ready, m1_addr, m1_wdata, m1_wstrb, m1_rdata, m1_err: same as master 0, for master 1
- s_valid  output  1  slave request
- s_ready  input  1  slave completion pulse
- s_addr  output  32  latched address
- s_wdata  output  32  latched write data
- s_wstrb  output  4  latched write strobe
- s_rdata  input  32  slave read data
- busy  output  1  high in any grant state
- grant  output  1  index of the master owning the slave; meaningful only when busy=1

Behaviour:
- Clock and reset: clk; reset_n is synchronous, active-low.
- Reset values:
  - state=IDLE; last_grant=1, so master 0 wins the first tie.
  - All outputs 0; latched address, data and strobe 0; timeout counter 0.
  - Reset asserted mid-transaction abandons it with no ready pulse. A late s_ready after reset is ignored.
- States: IDLE, GRANT0, GRANT1, DONE.
- IDLE:
  - Only m0_valid=1 → GRANT0.
  - Only m1_valid=1 → GRANT1.
  - Both valid → grant the master that is not last_grant (round-robin).
  - On the transition edge, latch the winner's addr, wdata and wstrb into s_addr, s_wdata, s_wstrb, and clear the timeout counter.
- GRANTx:
  - s_valid=1, held constant until the transaction ends. Master x's valid and payload are ignored after the latch.
  - s_ready=1:
    - Assert mx_ready=1 combinationally in the same cycle, with mx_rdata=s_rdata and mx_err=0.
    - Set last_grant=x; next state DONE.
  - Otherwise the counter increments. When TIMEOUT_CYCLES≠0 and the counter equals TIMEOUT_CYCLES-1:
    - Assert mx_ready=1, mx_err=1, mx_rdata=ERR_RDATA.
    - Set last_grant=x; next state DONE.
- DONE:
  - One cycle with s_valid=0, then → IDLE.
  - This guarantees at least one idle cycle on the slave between transactions, so the slave cannot re-trigger on stale valid.
  - s_ready seen in DONE or IDLE is ignored.
- Ungranted master: its ready and err stay 0 and its rdata is 0.
- Master protocol: a master holds valid until its ready pulse and drops valid in the following cycle. A master that still holds valid in IDLE is treated as a new request.
- Latency: request seen in IDLE at edge t; s_valid high from t+1. Master ready = slave ready cycle (no extra cycle at the end). With the 3-wait BRAM controller, m_ready is high in cycle t+4.
- Throughput: one transaction per (slave latency + 2) cycles.
- Both masters valid continuously → grants strictly alternate 0,1,0,1.

Test Plan:
1. Reset, then m0 read of addr 0x10 alone → s_valid high cycle after request, s_addr=0x10, s_wstrb=0; m0_ready pulses one cycle with m0_rdata=slave word; m1_ready stays 0.
2. m1 write addr 0x20, wdata 0xCAFEBABE, wstrb 4'b1111; change m1_addr to 0x99 one cycle after grant → s_addr stays 0x20, s_wdata=0xCAFEBABE until s_ready; then one cycle with s_valid=0.
3. m0 and m1 valid in the same cycle after reset → m0 served first, then m1. Holding both valid continuously → grant sequence 0,1,0,1.
4. TIMEOUT_CYCLES=8, slave never asserts s_ready → m0_ready and m0_err pulse 8 cycles after grant with m0_rdata=0xDEADBEEF. An s_ready one cycle later is ignored.
5. reset_n low for one cycle during GRANT1 → next cycle state IDLE, s_valid=0, busy=0, no m1_ready; a subsequent tie grants m0.
6. Against the real BRAM controller: write 0x12345678 to 0x40, then read 0x40 → read returns 0x12345678, and each m_ready arrives 4 cycles after its request is seen.
